// File: rtl/axil_slave_regfile_pkg.sv
// Shared AXI-Lite response codes and channel FSM state types for the register-file slave.
package pkg_axil;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_slave_regfile_wr.sv
// Write channel of the AXI-Lite register-file slave: latches AW and W beats independently,
// reports a one-cycle commit with target index/data/strobes, then drives the B response.
//
// state  | meaning
// W_IDLE | accepting AW and/or W; commits once both beats are present
// W_RESP | bvalid held with bresp until the master takes it
module axil_slave_regfile_wr
  import pkg_axil::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 16,
  localparam int STRB_W        = AXI_DATA_WIDTH / 8,
  localparam int IDX_W         = $clog2(NUM_REGS)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_W-1:0]         s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  output logic                      commit_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic [AXI_DATA_WIDTH-1:0] wdata_o,
  output logic [STRB_W-1:0]         wstrb_o,
  output logic                      err_o
);

  localparam int HI_W = AXI_ADDR_WIDTH - 2;
  localparam logic [HI_W-1:0] NUM_REGS_A = HI_W'(NUM_REGS);

  wr_state_t                 state_q, state_d;
  logic                      aw_held_q, aw_held_d;
  logic                      w_held_q, w_held_d;
  logic [HI_W-1:0]           awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;

  logic            aw_hs, w_hs, aw_have, w_have;
  logic [HI_W-1:0] cur_addr;
  logic            unused_awaddr_lsb;

  assign unused_awaddr_lsb = ^s_axil_awaddr[1:0];

  assign aw_hs   = s_axil_awvalid && awready_q;
  assign w_hs    = s_axil_wvalid && wready_q;
  assign aw_have = aw_held_q || aw_hs;
  assign w_have  = w_held_q || w_hs;

  // A beat accepted on the commit edge is used directly rather than via its holding register
  assign cur_addr = aw_held_q ? awaddr_q : s_axil_awaddr[AXI_ADDR_WIDTH-1:2];
  assign wdata_o  = w_held_q ? wdata_q : s_axil_wdata;
  assign wstrb_o  = w_held_q ? wstrb_q : s_axil_wstrb;
  assign idx_o    = cur_addr[IDX_W-1:0];
  assign err_o    = (cur_addr >= NUM_REGS_A);

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit_o  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (aw_hs) awaddr_d = s_axil_awaddr[AXI_ADDR_WIDTH-1:2];
        if (w_hs) begin
          wdata_d = s_axil_wdata;
          wstrb_d = s_axil_wstrb;
        end
        if (aw_have && w_have) begin
          commit_o  = 1'b1;
          state_d   = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = err_o ? AXI_SLVERR : AXI_OKAY;
        end else begin
          aw_held_d = aw_have;
          w_held_d  = w_have;
          awready_d = !aw_have;
          wready_d  = !w_have;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          state_d   = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave with NUM_REGS read/write registers exported to user logic, plus a write-notify strobe.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid held with rdata/rresp until the master takes it
module axil_slave_regfile
  import pkg_axil::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                               s_axil_awvalid,
  output logic                               s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                               s_axil_wvalid,
  output logic                               s_axil_wready,
  output logic [1:0]                         s_axil_bresp,
  output logic                               s_axil_bvalid,
  input  logic                               s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                               s_axil_arvalid,
  output logic                               s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic                               s_axil_rvalid,
  input  logic                               s_axil_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
  output logic                               reg_wr_stb,
  output logic [$clog2(NUM_REGS)-1:0]        reg_wr_idx
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int HI_W   = AXI_ADDR_WIDTH - 2;
  localparam logic [HI_W-1:0] NUM_REGS_A = HI_W'(NUM_REGS);

  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                      wr_commit, wr_err;
  logic [IDX_W-1:0]          wr_idx;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_stb_q;
  logic [IDX_W-1:0]          wr_idx_q;

  axil_slave_regfile_wr #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .NUM_REGS      (NUM_REGS)
  ) u_wr (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .commit_o      (wr_commit),
    .idx_o         (wr_idx),
    .wdata_o       (wr_data),
    .wstrb_o       (wr_strb),
    .err_o         (wr_err)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit && !wr_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_stb_q <= wr_commit && !wr_err;
      if (wr_commit && !wr_err) wr_idx_q <= wr_idx;
    end
  end

  assign reg_wr_stb = wr_stb_q;
  assign reg_wr_idx = wr_idx_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign reg_q[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
  end

  rd_state_t                 rd_state_q, rd_state_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic            ar_hs, ar_err;
  logic [HI_W-1:0] ar_hi;
  logic            unused_araddr_lsb;

  assign unused_araddr_lsb = ^s_axil_araddr[1:0];
  assign ar_hi  = s_axil_araddr[AXI_ADDR_WIDTH-1:2];
  assign ar_err = (ar_hi >= NUM_REGS_A);
  assign ar_hs  = s_axil_arvalid && arready_q;

  // regs_q is sampled before this edge's write lands, so a same-edge collision returns the old value
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = ar_err ? '0 : regs_q[ar_hi[IDX_W-1:0]];
          rresp_d    = ar_err ? AXI_SLVERR : AXI_OKAY;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axil_rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= AXI_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed and randomized bench for axil_slave_regfile against an array-based register model.
module tb_axil_slave_regfile;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  s_axil_awaddr;
  logic         s_axil_awvalid;
  logic         s_axil_awready;
  logic [31:0]  s_axil_wdata;
  logic [3:0]   s_axil_wstrb;
  logic         s_axil_wvalid;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready;
  logic [31:0]  s_axil_araddr;
  logic         s_axil_arvalid;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready;
  logic [511:0] reg_q;
  logic         reg_wr_stb;
  logic [3:0]   reg_wr_idx;

  axil_slave_regfile #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .NUM_REGS      (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .s_axil_araddr (s_axil_araddr),
    .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready),
    .reg_q         (reg_q),
    .reg_wr_stb    (reg_wr_stb),
    .reg_wr_idx    (reg_wr_idx)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_reg%0d", tag, i), reg_q[i*32 +: 32], model[i]);
  endtask

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int idx;
    logic [31:0] w;
    if (addr[31:2] >= 30'd16) return;
    idx = int'(addr[5:2]);
    w = model[idx];
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    model[idx] = w;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int c, stb_cnt;
    logic aw_done, w_done, aw_hs, w_hs, in_rng;
    logic [3:0] stb_idx;
    logic [1:0] exp_resp;
    in_rng   = (addr[31:2] < 30'd16);
    exp_resp = in_rng ? 2'b00 : 2'b10;
    c = 0; stb_cnt = 0; stb_idx = '0; aw_done = 1'b0; w_done = 1'b0;
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    while (!(aw_done && w_done) && c < 60) begin
      s_axil_awvalid = !aw_done && (c >= aw_dly);
      s_axil_wvalid  = !w_done && (c >= w_dly);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(negedge aclk);
      c++;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      if (reg_wr_stb) begin stb_cnt++; stb_idx = reg_wr_idx; end
      if (aw_done && !w_done) check("awready_low_after_aw", s_axil_awready, 0);
      if (w_done && !aw_done) check("wready_low_after_w", s_axil_wready, 0);
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    check("write_handshake_in_budget", aw_done && w_done, 1);
    check("bvalid_after_commit", s_axil_bvalid, 1);
    check("bresp", s_axil_bresp, exp_resp);
    model_write(addr, data, strb);
    check_regs("regs_after_write");
    for (int k = 0; k < b_dly; k++) begin
      s_axil_bready = 1'b0;
      @(negedge aclk);
      if (reg_wr_stb) stb_cnt++;
      check("b_hold", {s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready},
            {1'b1, exp_resp, 2'b00});
    end
    s_axil_bready = 1'b1;
    @(negedge aclk);
    s_axil_bready = 1'b0;
    if (reg_wr_stb) stb_cnt++;
    check("bvalid_clear", s_axil_bvalid, 0);
    check("readies_after_b", {s_axil_awready, s_axil_wready}, 2'b11);
    check("stb_count", stb_cnt, in_rng ? 1 : 0);
    if (in_rng) check("stb_idx", stb_idx, addr[5:2]);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data);
    int c;
    logic done, hs, in_rng;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    in_rng   = (addr[31:2] < 30'd16);
    exp_data = in_rng ? model[int'(addr[5:2])] : 32'h0;
    exp_resp = in_rng ? 2'b00 : 2'b10;
    c = 0; done = 1'b0;
    s_axil_araddr = addr;
    while (!done && c < 60) begin
      s_axil_arvalid = (c >= ar_dly);
      hs = s_axil_arvalid && s_axil_arready;
      @(negedge aclk);
      c++;
      done = hs;
    end
    s_axil_arvalid = 1'b0;
    check("read_handshake_in_budget", done, 1);
    check("rvalid_after_ar", s_axil_rvalid, 1);
    check("rdata", s_axil_rdata, exp_data);
    check("rresp", s_axil_rresp, exp_resp);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge aclk);
      check("r_hold", {s_axil_rvalid, s_axil_rdata, s_axil_rresp, s_axil_arready},
            {1'b1, exp_data, exp_resp, 1'b0});
    end
    data = s_axil_rdata;
    s_axil_rready = 1'b1;
    @(negedge aclk);
    s_axil_rready = 1'b0;
    check("rvalid_clear", s_axil_rvalid, 0);
    check("arready_after_r", s_axil_arready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready,
                           s_axil_rvalid, reg_wr_stb}, 6'b0);
    check({tag, "_resp_data"}, {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 36'h0);
    check_regs(tag);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic [3:0]  s;
    aresetn = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    repeat (2) @(negedge aclk);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);
    check("readies_after_reset", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // AW and W together, then read back
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h08, 0, 0, rd);
    check("t1_rdata", rd, 32'hDEADBEEF);

    // W leads AW by three cycles
    axi_write(32'h0C, 32'h12345678, 4'hF, 3, 0, 0);
    check("t2_reg3", reg_q[3*32 +: 32], 32'h12345678);
    axi_write(32'h1F, 32'hCAFEF00D, 4'hF, 0, 2, 1);

    // byte strobes, including an empty strobe
    axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'h00000000, 4'b0101, 1, 0, 0);
    check("t3_reg1", reg_q[1*32 +: 32], 32'hFF00FF00);
    axi_write(32'h04, 32'h00000000, 4'b0000, 0, 0, 0);
    check("t3_reg1_nostrb", reg_q[1*32 +: 32], 32'hFF00FF00);

    // out of range
    axi_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0, 0, rd);
    axi_read(32'hFFFF_FFFC, 1, 0, rd);

    // back-pressure on B and R
    axi_write(32'h18, 32'h0BADCAFE, 4'hF, 0, 0, 5);
    axi_read(32'h18, 0, 5, rd);

    // same-edge write commit and read of the same register
    axi_write(32'h10, 32'h11111111, 4'hF, 0, 0, 0);
    s_axil_awaddr = 32'h10; s_axil_wdata = 32'h22222222; s_axil_wstrb = 4'hF;
    s_axil_araddr = 32'h10;
    check("t6_all_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    model[4] = 32'h22222222;
    check("t6_valids", {s_axil_bvalid, s_axil_rvalid, reg_wr_stb}, 3'b111);
    check("t6_rdata_old", s_axil_rdata, 32'h11111111);
    check("t6_reg4_new", reg_q[4*32 +: 32], 32'h22222222);
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    @(negedge aclk);
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    check("t6_done", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    axi_read(32'h10, 0, 0, rd);
    check("t6_rdata_new", rd, 32'h22222222);

    // reset with an AW beat pending
    s_axil_awaddr = 32'h04; s_axil_awvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0;
    check("pending_aw_held", s_axil_awready, 0);
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    check_reset_outputs("midreset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    axi_write(32'h14, 32'hAAAAAAAA, 4'hF, 2, 0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      a = {26'h0, 4'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      a = {26'h0, 4'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
      axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_slave_regfile.md
Name: axil_slave_regfile

Overview:
AXI-Lite slave (responder) holding NUM_REGS 32-bit read/write registers. It is the far end of the link driven by our AXI-Lite master and replaces the behavioural slave model in the master bench with synthesizable RTL. Write and read paths are independent FSMs. Register contents are exported to user logic, with a one-cycle write-notify strobe.

Parameters:
AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
AXI_ADDR_WIDTH, 32, address bus width.
NUM_REGS, 16, number of registers; power of 2, 2..256.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axil_awaddr  in  AXI_ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  AXI_DATA_WIDTH  write data
s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  AXI_ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  AXI_DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
reg_q  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; reg i is at [i*32 +: 32]
reg_wr_stb  out  1  one-cycle pulse on each committed in-range write
reg_wr_idx  out  $clog2(NUM_REGS)  index of the register written; valid with reg_wr_stb

Behaviour:
- Reset (aresetn=0, asynchronous): all registers 0. awready, wready, bvalid, arready, rvalid and reg_wr_stb are 0. bresp, rresp and rdata are 0.
- Addressing: idx = addr[2 +: $clog2(NUM_REGS)]; addr[1:0] is ignored. An address is in range iff addr[AXI_ADDR_WIDTH-1:2] < NUM_REGS. Out-of-range accesses get SLVERR (2'b10). In-range accesses get OKAY (2'b00).
- Write FSM, states W_IDLE and W_RESP.
  - In W_IDLE, awready=1 until an AW beat is latched, and wready=1 until a W beat is latched. Both are registered and rise on the first cycle after reset release.
  - AW and W may arrive in either order or in the same cycle. Each beat is latched independently.
  - On the edge where both beats are held or being accepted, the write commits:
    - For each byte b with wstrb[b]=1, reg[idx] byte b takes wdata byte b.
    - reg_wr_stb=1 for that one cycle (in-range writes only).
    - bvalid=1 with the appropriate bresp; state moves to W_RESP.
  - Latency: the last of the AW/W handshakes is at edge T; the register update, bvalid and reg_wr_stb are all visible after edge T.
  - wstrb=0 in range: no bytes change, reg_wr_stb still pulses, response is OKAY.
  - Out-of-range write: no register changes, no strobe, SLVERR.
  - W_RESP: awready=wready=0. bvalid and bresp are held until bready. On the bvalid&&bready edge, go to W_IDLE with both readies 1 on the next cycle.
  - Throughput: at most 1 write per 2 cycles.
- Read FSM, states R_IDLE and R_DATA.
  - R_IDLE: arready=1. On the arvalid&&arready edge T, rdata/rresp are captured, rvalid=1 after T, and the state moves to R_DATA with arready=0.
  - Out-of-range read: rdata=0, SLVERR.
  - R_DATA: rdata, rresp and rvalid are held stable until rready. On handshake, return to R_IDLE with arready=1 next cycle.
- Read/write collision: if a write commit and an AR handshake target the same register on the same edge, rdata returns the pre-write value.
- A read accepted one or more cycles after the commit returns the new value.
- The read and write FSMs never stall each other.
- Mid-operation reset: both FSMs return to idle, pending latched beats are discarded, and registers clear.

Decomposition:
- Shared package (pkg_axil): AXI_OKAY=2'b00, AXI_SLVERR=2'b10, AXI_DECERR=2'b11, plus the wr_state_t and rd_state_t enums.
- Sub-module axil_slave_regfile_wr: write-channel FSM (AW/W latching, commit, B channel) emitting commit, idx, wdata, wstrb and err.
- The register array and read FSM stay in the top module.

Test Plan:
1. Write 0xDEADBEEF to 0x08 with AW and W in the same cycle, then read 0x08 -> bresp OKAY, reg_wr_stb with idx 2, rdata 0xDEADBEEF, rresp OKAY.
2. W driven 3 cycles before AW for addr 0x0C, data 0x12345678 -> wready drops after the W beat, bvalid the cycle after the AW handshake, reg_q[3] = 0x12345678.
3. Reg 1 = 0xFFFFFFFF; write 0x00000000 with wstrb 4'b0101 -> reg 1 = 0xFF00FF00.
4. Write and read to addr 0x40 with NUM_REGS=16 -> both SLVERR, rdata 0, no reg_wr_stb, reg_q unchanged.
5. Hold bready=0 for 5 cycles, and rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata stay stable, and awready/arready stay 0 until the handshake.
6. Reg 4 = 0x11111111; on the same edge commit 0x22222222 to reg 4 and accept a read of 0x10 -> rdata 0x11111111; the next read returns 0x22222222.
